axi_ddr_responder: RTL
======================

Name: axi_ddr_responder

Overview:
- AXI slave (responder) with on-chip RAM. Answers the AW/W/B write channels and AR/R read channels driven by the frame buffer's rx/tx DDR buffers.
- Serves as the DDR-controller stand-in for block and system simulation, and as a small on-chip frame store for reduced-resolution builds.
- Supports one outstanding write burst and one outstanding read burst; the two channels run concurrently and independently.

Parameters:
- AXI_ID_WIDTH, 8, width of all ID fields
- AXI_ADDR_WIDTH, 32, byte address width
- AXI_DATA_WIDTH, 256, data bus width; must be a power of 2, 32 or more
- AXI_BYTE_NUMBER, AXI_DATA_WIDTH/8, strobe width
- MEM_AW, 12, log2 of RAM depth in data words
- RD_LATENCY, 2, idle cycles between AR handshake and first R beat (1..15)

Ports:
- axi_clk in 1: sole clock
- rst in 1: synchronous, active-high reset
- axi_awid in AXI_ID_WIDTH; axi_awaddr in AXI_ADDR_WIDTH; axi_awlen in 8; axi_awsize in 3; axi_awburst in 2; axi_awlock in 1 (ignored); axi_awvalid in 1; axi_awready out 1
- axi_wid in AXI_ID_WIDTH (ignored); axi_wdata in AXI_DATA_WIDTH; axi_wstrb in AXI_BYTE_NUMBER; axi_wlast in 1; axi_wvalid in 1; axi_wready out 1
- axi_bid out AXI_ID_WIDTH; axi_bresp out 2; axi_bvalid out 1; axi_bready in 1
- axi_arid in AXI_ID_WIDTH; axi_araddr in AXI_ADDR_WIDTH; axi_arlen in 8; axi_arsize in 3; axi_arburst in 2; axi_arlock in 1 (ignored); axi_arvalid in 1; axi_arready out 1
- axi_rid out AXI_ID_WIDTH; axi_rdata out AXI_DATA_WIDTH; axi_rresp out 2; axi_rlast out 1; axi_rvalid out 1; axi_rready in 1
- wr_burst_cnt out 16: completed B handshakes, wraps modulo 2^16
- rd_burst_cnt out 16: completed R bursts (rlast handshakes), wraps modulo 2^16

Behaviour:
- Reset values: every output is 0 (including rdata and both counters). RAM contents are not reset.
- Reset mid-burst aborts both FSMs to IDLE. No B response and no further R beats are issued for the aborted burst.
- Word index = addr[LSB+MEM_AW-1:LSB], where LSB = log2(AXI_BYTE_NUMBER). Upper address bits are ignored, so the RAM aliases. The index increments by 1 per beat and wraps from 2^MEM_AW-1 to 0.
- A burst is legal only when burst == 2'b01 (INCR) and size == LSB.
  - Illegal burst on the write side: it is still fully accepted, with no RAM writes, and answered with resp SLVERR (2'b10).
  - Illegal burst on the read side: rdata = 0 and rresp = SLVERR on every beat.
  - Legal bursts return OKAY (2'b00).
- Write FSM, W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
  - W_IDLE: awready = 1. On awvalid & awready, latch id, index, awlen and the legal flag; go to W_DATA with beat = 0.
  - W_DATA: wready = 1. Each wvalid & wready writes the bytes enabled by wstrb at the current index (only if legal), then beat++.
  - W_DATA termination: beat count governs, and the state is left after beat == awlen. wlast must be 1 on exactly that beat. A wlast mismatch (early or missing) forces bresp = SLVERR but does not change termination.
  - W_RESP: bvalid = 1 with bid/bresp held stable until bready. wr_burst_cnt++ on the handshake, then return to W_IDLE. awready is 0 outside W_IDLE.
- Read FSM, R_IDLE -> R_WAIT -> R_DATA -> R_IDLE:
  - R_IDLE: arready = 1. On handshake at cycle T, latch id, index, arlen and the legal flag; go to R_WAIT.
  - R_WAIT: the first rvalid is asserted at cycle T+1+RD_LATENCY.
  - R_DATA: rvalid held high. rdata/rid/rresp/rlast are held stable while rready = 0. The next beat is presented on the cycle after each rvalid & rready, giving zero bubbles under continuous rready.
  - rlast = 1 only on beat arlen. After the rlast handshake, rd_burst_cnt++ and return to R_IDLE; arready is reasserted the following cycle.
- Collision: a read of a word written in the same cycle returns the pre-write contents (read-first). A write completed before the read beat's fetch is visible to it.
- Length: awlen/arlen of 0..255 give 1..256 beats; no 4 KB boundary check.

Test Plan:
- Single beat: write awaddr 0x40, awlen 0, wdata 0xA5..A5, wstrb all-ones, then read 0x40 -> bresp 0, bid = awid, rdata 0xA5..A5, rlast = 1 on the only beat, rresp 0, first rvalid exactly 3 cycles after the AR handshake.
- 128-beat burst: write awlen 127 with an incrementing data pattern, read it back with rready toggling 1-0-1 -> all 128 words match, rdata stable while rready = 0, rlast only on beat 127, rd_burst_cnt = 1.
- Partial strobe: preload word 5 with all-ones, write wstrb = 0x0000_000F with wdata = 0 -> read returns low 4 bytes 0, remaining bytes 0xFF.
- Errors:
  - awburst 2'b00 -> bresp 2'b10 and RAM unchanged.
  - wlast asserted on beat 2 of a 4-beat burst -> 4 beats still accepted, bresp 2'b10.
  - arsize 3'd2 -> every beat rresp 2'b10 with rdata 0.
- Wrap: write at index 2^MEM_AW-2 with awlen 3 -> data lands at indices 4094, 4095, 0, 1; readback at 0 returns beat 2.
- Reset: assert rst after 10 of 64 write beats -> all outputs 0 next cycle, no bvalid. A new AW is then accepted (awready = 1) on the first cycle after rst deasserts.

Source files
------------

// File: rtl/axi_ddr_responder_if.sv
// AXI bus bundle between the frame-buffer DDR buffers (master) and the
// on-chip RAM responder (slave).
`timescale 1ns/1ps
interface axi_ddr_responder_if #(
    parameter int AXI_ID_WIDTH    = 8,
    parameter int AXI_ADDR_WIDTH  = 32,
    parameter int AXI_DATA_WIDTH  = 256,
    parameter int AXI_BYTE_NUMBER = AXI_DATA_WIDTH / 8
);
    logic [AXI_ID_WIDTH-1:0]    axi_awid;
    logic [AXI_ADDR_WIDTH-1:0]  axi_awaddr;
    logic [7:0]                 axi_awlen;
    logic [2:0]                 axi_awsize;
    logic [1:0]                 axi_awburst;
    logic                       axi_awlock;
    logic                       axi_awvalid;
    logic                       axi_awready;

    logic [AXI_ID_WIDTH-1:0]    axi_wid;
    logic [AXI_DATA_WIDTH-1:0]  axi_wdata;
    logic [AXI_BYTE_NUMBER-1:0] axi_wstrb;
    logic                       axi_wlast;
    logic                       axi_wvalid;
    logic                       axi_wready;

    logic [AXI_ID_WIDTH-1:0]    axi_bid;
    logic [1:0]                 axi_bresp;
    logic                       axi_bvalid;
    logic                       axi_bready;

    logic [AXI_ID_WIDTH-1:0]    axi_arid;
    logic [AXI_ADDR_WIDTH-1:0]  axi_araddr;
    logic [7:0]                 axi_arlen;
    logic [2:0]                 axi_arsize;
    logic [1:0]                 axi_arburst;
    logic                       axi_arlock;
    logic                       axi_arvalid;
    logic                       axi_arready;

    logic [AXI_ID_WIDTH-1:0]    axi_rid;
    logic [AXI_DATA_WIDTH-1:0]  axi_rdata;
    logic [1:0]                 axi_rresp;
    logic                       axi_rlast;
    logic                       axi_rvalid;
    logic                       axi_rready;

    modport master (
        output axi_awid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst, axi_awlock, axi_awvalid,
        input  axi_awready,
        output axi_wid, axi_wdata, axi_wstrb, axi_wlast, axi_wvalid,
        input  axi_wready,
        input  axi_bid, axi_bresp, axi_bvalid,
        output axi_bready,
        output axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst, axi_arlock, axi_arvalid,
        input  axi_arready,
        input  axi_rid, axi_rdata, axi_rresp, axi_rlast, axi_rvalid,
        output axi_rready
    );

    modport slave (
        input  axi_awid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst, axi_awlock, axi_awvalid,
        output axi_awready,
        input  axi_wid, axi_wdata, axi_wstrb, axi_wlast, axi_wvalid,
        output axi_wready,
        output axi_bid, axi_bresp, axi_bvalid,
        input  axi_bready,
        input  axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst, axi_arlock, axi_arvalid,
        output axi_arready,
        output axi_rid, axi_rdata, axi_rresp, axi_rlast, axi_rvalid,
        input  axi_rready
    );
endinterface

// File: rtl/axi_ddr_responder.sv
// AXI responder backed by on-chip RAM: one write and one read burst in flight,
// running independently. Stands in for the DDR controller in simulation.
`timescale 1ns/1ps
module axi_ddr_responder #(
    parameter int AXI_ID_WIDTH    = 8,
    parameter int AXI_ADDR_WIDTH  = 32,
    parameter int AXI_DATA_WIDTH  = 256,
    parameter int AXI_BYTE_NUMBER = AXI_DATA_WIDTH / 8,
    parameter int MEM_AW          = 12,
    parameter int RD_LATENCY      = 2
) (
    input  logic               axi_clk,
    input  logic               rst,
    axi_ddr_responder_if.slave axi,
    output logic [15:0]        wr_burst_cnt,
    output logic [15:0]        rd_burst_cnt
);
    localparam int         LSB         = $clog2(AXI_BYTE_NUMBER);
    localparam int         DEPTH       = 1 << MEM_AW;
    localparam logic [2:0] LEGAL_SIZE  = 3'(LSB);
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;
    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_WAIT = 2'd1;
    localparam logic [1:0] R_DATA = 2'd2;

    logic [AXI_DATA_WIDTH-1:0] mem [DEPTH];

    logic [1:0]              w_state;
    logic [AXI_ID_WIDTH-1:0] w_id;
    logic [MEM_AW-1:0]       w_idx;
    logic [7:0]              w_len;
    logic [7:0]              w_beat;
    logic                    w_legal;
    logic                    w_err;
    logic                    w_fire;
    logic                    aw_legal;

    logic [1:0]              r_state;
    logic [AXI_ID_WIDTH-1:0] r_id;
    logic [MEM_AW-1:0]       r_idx;
    logic [MEM_AW-1:0]       r_idx_nxt;
    logic [7:0]              r_len;
    logic [7:0]              r_beat;
    logic [7:0]              r_beat_nxt;
    logic                    r_legal;
    logic [3:0]              r_wait;
    logic                    ar_legal;

    logic [AXI_ADDR_WIDTH-1:0] unused_addr;
    logic                      unused_bits;

    assign unused_addr = axi.axi_awaddr ^ axi.axi_araddr;
    assign unused_bits = ^{axi.axi_awlock, axi.axi_arlock, axi.axi_wid};

    // Readies are gated by rst so the bus looks idle during reset and is live
    // on the very first cycle after it.
    assign axi.axi_awready = (w_state == W_IDLE) && !rst;
    assign axi.axi_wready  = (w_state == W_DATA) && !rst;
    assign axi.axi_arready = (r_state == R_IDLE) && !rst;

    assign w_fire     = axi.axi_wvalid && axi.axi_wready;
    assign aw_legal   = (axi.axi_awburst == BURST_INCR) && (axi.axi_awsize == LEGAL_SIZE);
    assign ar_legal   = (axi.axi_arburst == BURST_INCR) && (axi.axi_arsize == LEGAL_SIZE);
    assign r_idx_nxt  = r_idx + 1'b1;
    assign r_beat_nxt = r_beat + 8'd1;

    always_ff @(posedge axi_clk) begin
        if (rst) begin
            w_state        <= W_IDLE;
            w_id           <= '0;
            w_idx          <= '0;
            w_len          <= '0;
            w_beat         <= '0;
            w_legal        <= 1'b0;
            w_err          <= 1'b0;
            axi.axi_bvalid <= 1'b0;
            axi.axi_bid    <= '0;
            axi.axi_bresp  <= RESP_OKAY;
            wr_burst_cnt   <= '0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (axi.axi_awvalid) begin
                        w_id    <= axi.axi_awid;
                        w_idx   <= axi.axi_awaddr[LSB+MEM_AW-1:LSB];
                        w_len   <= axi.axi_awlen;
                        w_beat  <= '0;
                        w_legal <= aw_legal;
                        w_err   <= !aw_legal;
                        w_state <= W_DATA;
                    end
                end
                // Beat count ends the burst; wlast only affects the response.
                W_DATA: begin
                    if (w_fire) begin
                        w_idx  <= w_idx + 1'b1;
                        w_beat <= w_beat + 8'd1;
                        if (w_beat == w_len) begin
                            w_state        <= W_RESP;
                            axi.axi_bvalid <= 1'b1;
                            axi.axi_bid    <= w_id;
                            axi.axi_bresp  <= (w_err || !axi.axi_wlast) ? RESP_SLVERR : RESP_OKAY;
                        end else if (axi.axi_wlast) begin
                            w_err <= 1'b1;
                        end
                    end
                end
                W_RESP: begin
                    if (axi.axi_bready) begin
                        axi.axi_bvalid <= 1'b0;
                        wr_burst_cnt   <= wr_burst_cnt + 16'd1;
                        w_state        <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge axi_clk) begin
        if (w_fire && w_legal) begin
            for (int b = 0; b < AXI_BYTE_NUMBER; b++) begin
                if (axi.axi_wstrb[b]) begin
                    mem[w_idx][b*8 +: 8] <= axi.axi_wdata[b*8 +: 8];
                end
            end
        end
    end

    // Each beat is fetched the cycle before it is presented; a same-cycle
    // write to that word is not yet visible (read-first).
    always_ff @(posedge axi_clk) begin
        if (rst) begin
            r_state        <= R_IDLE;
            r_id           <= '0;
            r_idx          <= '0;
            r_len          <= '0;
            r_beat         <= '0;
            r_legal        <= 1'b0;
            r_wait         <= '0;
            axi.axi_rvalid <= 1'b0;
            axi.axi_rid    <= '0;
            axi.axi_rdata  <= '0;
            axi.axi_rresp  <= RESP_OKAY;
            axi.axi_rlast  <= 1'b0;
            rd_burst_cnt   <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (axi.axi_arvalid) begin
                        r_id    <= axi.axi_arid;
                        r_idx   <= axi.axi_araddr[LSB+MEM_AW-1:LSB];
                        r_len   <= axi.axi_arlen;
                        r_beat  <= '0;
                        r_legal <= ar_legal;
                        r_wait  <= 4'(RD_LATENCY - 1);
                        r_state <= R_WAIT;
                    end
                end
                R_WAIT: begin
                    if (r_wait == 4'd0) begin
                        r_state        <= R_DATA;
                        axi.axi_rvalid <= 1'b1;
                        axi.axi_rid    <= r_id;
                        axi.axi_rdata  <= r_legal ? mem[r_idx] : '0;
                        axi.axi_rresp  <= r_legal ? RESP_OKAY : RESP_SLVERR;
                        axi.axi_rlast  <= (r_len == 8'd0);
                    end else begin
                        r_wait <= r_wait - 4'd1;
                    end
                end
                R_DATA: begin
                    if (axi.axi_rready) begin
                        if (axi.axi_rlast) begin
                            axi.axi_rvalid <= 1'b0;
                            axi.axi_rlast  <= 1'b0;
                            rd_burst_cnt   <= rd_burst_cnt + 16'd1;
                            r_state        <= R_IDLE;
                        end else begin
                            r_idx         <= r_idx_nxt;
                            r_beat        <= r_beat_nxt;
                            axi.axi_rdata <= r_legal ? mem[r_idx_nxt] : '0;
                            axi.axi_rlast <= (r_beat_nxt == r_len);
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end
endmodule
